// File: rtl/call_display_driver_pkg.sv
// Shared definitions for call_display_driver: state encodings, active-low segment
// patterns, valid counter-id range and the constant-compare decimal split.
package call_display_driver_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLINK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_LET_A = 7'b0001000;
  localparam logic [6:0] SEG_LET_B = 7'b0000011;
  localparam logic [6:0] SEG_LET_C = 7'b1000110;
  localparam logic [6:0] SEG_LET_D = 7'b0100001;
  localparam logic [6:0] SEG_LET_E = 7'b0000110;

  localparam logic [6:0] SEG_DIG_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIG_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIG_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIG_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIG_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIG_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIG_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIG_7 = 7'b1111000;
  localparam logic [6:0] SEG_DIG_8 = 7'b0000000;
  localparam logic [6:0] SEG_DIG_9 = 7'b0010000;

  localparam logic [3:0] ID_MIN = 4'd1;
  localparam logic [3:0] ID_MAX = 4'd5;

  // Symbol codes fed to seg7_encode: 0..9 digits, 10..14 letters A..E, 15 dash.
  localparam logic [3:0] SYM_LETTER_BASE = 4'd9;
  localparam logic [3:0] SYM_DASH        = 4'd15;

  // Returns {tens[2:0], units[3:0]} for a 0..63 value using fixed subtract steps.
  function automatic logic [6:0] splitDecimal(input logic [5:0] n);
    logic [5:0] r;
    logic [2:0] t;
    r = n;
    t = 3'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 3'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 3'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 3'd1; end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/call_display_driver_seg7_encode.sv
// seg7_encode: combinational symbol-to-pattern lookup for the call display
// (digits 0..9, letters A..E, dash, plus an explicit blank override).
module seg7_encode
  import call_display_driver_pkg::*;
(
  input  logic [3:0] sym,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (sym)
        4'd0:    pattern = SEG_DIG_0;
        4'd1:    pattern = SEG_DIG_1;
        4'd2:    pattern = SEG_DIG_2;
        4'd3:    pattern = SEG_DIG_3;
        4'd4:    pattern = SEG_DIG_4;
        4'd5:    pattern = SEG_DIG_5;
        4'd6:    pattern = SEG_DIG_6;
        4'd7:    pattern = SEG_DIG_7;
        4'd8:    pattern = SEG_DIG_8;
        4'd9:    pattern = SEG_DIG_9;
        4'd10:   pattern = SEG_LET_A;
        4'd11:   pattern = SEG_LET_B;
        4'd12:   pattern = SEG_LET_C;
        4'd13:   pattern = SEG_LET_D;
        4'd14:   pattern = SEG_LET_E;
        default: pattern = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/call_display_driver.sv
// call_display_driver: latches each valid call and shows "<letter>-<number>" on a
// 4-digit active-low multiplexed display, blinking after each call. Optional chime via CALL_DISPLAY_CHIME_EN.
module call_display_driver
  import call_display_driver_pkg::*;
#(
  parameter int SCAN_DIV    = 4,
  parameter int BLINK_DIV   = 8,
  parameter int BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [3:0] counter_call,
  input  logic [5:0] number_service,
  output logic [6:0] seg,
  output logic [3:0] an,
`ifdef CALL_DISPLAY_CHIME_EN
  output logic       chime,
`endif
  output logic [1:0] dbgState
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [PW-1:0] PSC_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] PAIR_LAST  = CW'(BLINK_COUNT - 1);

  logic [1:0]    state;
  logic [PW-1:0] psc;
  logic [1:0]    idx;
  logic [BW-1:0] blinkCnt;
  logic          phaseOff;
  logic [CW-1:0] pairCnt;
  logic [2:0]    latId;
  logic [5:0]    latNum;

  logic          callOk;
  logic [6:0]    digits;
  logic [3:0]    sym;
  logic          symBlank;
  logic [6:0]    segNext;
  logic [3:0]    anNext;
  logic          chimeNext;

  // call_valid is a single-cycle pulse with no ready: the display accepts every
  // valid call immediately, and an invalid counter id is dropped without effect.
  assign callOk   = call_valid && (counter_call >= ID_MIN) && (counter_call <= ID_MAX);
  assign dbgState = state;

  always_comb begin
    digits    = splitDecimal(latNum);
    sym       = SYM_DASH;
    symBlank  = 1'b0;
    if (state != IDLE) begin
      case (idx)
        2'd0:    sym = digits[3:0];
        2'd1:    begin
                   sym      = {1'b0, digits[6:4]};
                   symBlank = (digits[6:4] == 3'd0);
                 end
        2'd2:    sym = SYM_DASH;
        default: sym = SYM_LETTER_BASE + {1'b0, latId};
      endcase
    end
    // Blink OFF only gates the anodes; the segment scan keeps running.
    anNext    = (state == BLINK && phaseOff) ? 4'hF : ~(4'b0001 << idx);
    chimeNext = (state == BLINK) && !phaseOff;
  end

  seg7_encode u_seg7_encode (
    .sym     (sym),
    .blank   (symBlank),
    .pattern (segNext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      psc      <= '0;
      idx      <= 2'd0;
      blinkCnt <= '0;
      phaseOff <= 1'b0;
      pairCnt  <= '0;
      latId    <= 3'd0;
      latNum   <= 6'd0;
      seg      <= SEG_BLANK;
      an       <= 4'hF;
    end else begin
      if (psc == PSC_LAST) begin
        psc <= '0;
        idx <= idx + 2'd1;
      end else begin
        psc <= psc + 1'b1;
      end

      if (callOk) begin
        state    <= BLINK;
        latId    <= counter_call[2:0];
        latNum   <= number_service;
        blinkCnt <= '0;
        phaseOff <= 1'b0;
        pairCnt  <= '0;
      end else if (state == BLINK) begin
        if (blinkCnt == BLINK_LAST) begin
          blinkCnt <= '0;
          phaseOff <= ~phaseOff;
          if (phaseOff) begin
            if (pairCnt == PAIR_LAST) begin
              state   <= SHOW;
              pairCnt <= '0;
            end else begin
              pairCnt <= pairCnt + 1'b1;
            end
          end
        end else begin
          blinkCnt <= blinkCnt + 1'b1;
        end
      end

      seg <= segNext;
      an  <= anNext;
    end
  end

`ifdef CALL_DISPLAY_CHIME_EN
  always_ff @(posedge clk) begin
    if (rst) chime <= 1'b0;
    else     chime <= chimeNext;
  end
`else
  logic unusedChime;
  assign unusedChime = chimeNext;
`endif

endmodule

// File: tb/tb_call_display_driver.sv
// Bench for call_display_driver: randomized and directed calls against a
// time-based reference model, scoreboard queue checked by an independent monitor.
module tb_call_display_driver;
  import call_display_driver_pkg::*;

  localparam int SCAN_DIV    = 4;
  localparam int BLINK_DIV   = 8;
  localparam int BLINK_COUNT = 3;
  localparam int BLINK_LEN   = 2 * BLINK_DIV * BLINK_COUNT;
  localparam int W           = 14;
`ifdef CALL_DISPLAY_CHIME_EN
  localparam bit CHIME = 1'b1;
`else
  localparam bit CHIME = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call_valid = 1'b0;
  logic [3:0] counter_call = 4'd0;
  logic [5:0] number_service = 6'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       chimeSig;
  logic [1:0] dbgState;

  call_display_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_DIV   (BLINK_DIV),
    .BLINK_COUNT (BLINK_COUNT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .call_valid     (call_valid),
    .counter_call   (counter_call),
    .number_service (number_service),
    .seg            (seg),
    .an             (an),
`ifdef CALL_DISPLAY_CHIME_EN
    .chime          (chimeSig),
`endif
    .dbgState       (dbgState)
  );

`ifndef CALL_DISPLAY_CHIME_EN
  assign chimeSig = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  // reference tables, written from the display code chart
  logic [6:0] digitSeg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0] letterSeg [5] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110};

  // reference model: time since reset and age of the current call
  int tScan   = 0;
  bit mCalled = 1'b0;
  int mAge    = 0;
  int mId     = 0;
  int mNum    = 0;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // driver: applies one cycle of inputs and queues the outputs expected after that edge
  task automatic drive(input bit r, input bit v, input int id, input int num);
    logic [6:0] s;
    logic [3:0] a;
    logic       ch;
    logic [1:0] st;
    logic [1:0] idx;
    bit         blinking;
    bit         off;
    @(negedge clk);
    rst            = r;
    call_valid     = v;
    counter_call   = id[3:0];
    number_service = num[5:0];
    if (r) begin
      s  = 7'h7F;
      a  = 4'hF;
      ch = 1'b0;
    end else begin
      idx      = 2'((tScan / SCAN_DIV) % 4);
      blinking = mCalled && (mAge < BLINK_LEN);
      off      = blinking && (((mAge / BLINK_DIV) % 2) == 1);
      if (!mCalled) s = 7'b0111111;
      else begin
        case (idx)
          2'd0:    s = digitSeg[mNum % 10];
          2'd1:    s = (mNum / 10 == 0) ? 7'h7F : digitSeg[mNum / 10];
          2'd2:    s = 7'b0111111;
          default: s = letterSeg[mId - 1];
        endcase
      end
      a  = off ? 4'hF : ~(4'b0001 << idx);
      ch = CHIME && blinking && !off;
    end
    if (r) begin
      tScan   = 0;
      mCalled = 1'b0;
      mAge    = 0;
    end else begin
      tScan++;
      if (v && id >= 1 && id <= 5) begin
        mCalled = 1'b1;
        mAge    = 0;
        mId     = id;
        mNum    = num;
      end else if (mCalled) begin
        mAge++;
      end
    end
    st = !mCalled ? IDLE : ((mAge < BLINK_LEN) ? BLINK : SHOW);
    exp_q.push_back({st, ch, a, s});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic call(input int id, input int num);
    drive(1'b0, 1'b1, id, num);
  endtask

  // scoreboard monitor: samples 1 time unit after each rising edge
  logic [W-1:0] expV;
  logic [W-1:0] gotV;
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      expV = exp_q.pop_front();
      gotV = {dbgState, chimeSig, an, seg};
      checks++;
      if (gotV !== expV) begin
        failures++;
        $display("FAIL disp cyc=%0d got st=%0d ch=%b an=%b seg=%b required st=%0d ch=%b an=%b seg=%b",
                 cycle, gotV[13:12], gotV[11], gotV[10:7], gotV[6:0],
                 expV[13:12], expV[11], expV[10:7], expV[6:0]);
      end
    end
  end

  initial begin
    // reset then idle dash scan
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    idle(40);

    // directed calls from the bring-up list
    call(1, 7);
    idle(60);
    call(5, 63);
    idle(60);
    call(3, 10);
    idle(19);
    call(2, 41);
    idle(60);

    // invalid ids in SHOW
    call(0, 12);
    idle(5);
    call(9, 33);
    idle(10);

    // reset mid-blink
    call(4, 25);
    idle(15);
    drive(1'b1, 1'b0, 0, 0);
    idle(20);

    // boundary numbers
    call(1, 0);
    idle(55);
    call(5, 9);
    idle(55);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0)
        drive(1'b1, 1'b0, 0, 0);
      else
        drive(1'b0, ($urandom_range(0, 29) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
    end
    idle(2);

    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
